// File: rtl/feistel_cipher_pkg.sv
// Shared constants, types and helper functions for the Feistel cipher core.
// The optional decrypt/round-key-buffer feature is selected with CIPHER_DECRYPT_EN.
package feistel_cipher_pkg;

  // Per-round constants mixed into F, indexed by the round number
  localparam logic [6:0] RC [16] = '{
    7'h5A, 7'h5A, 7'h33, 7'h66, 7'h57, 7'h35, 7'h71, 7'h62,
    7'h5F, 7'h25, 7'h51, 7'h22, 7'h0B, 7'h16, 7'h2C, 7'h58
  };

  // Register word addresses
  localparam logic [3:0] ADDR_DATA0  = 4'd0;
  localparam logic [3:0] ADDR_KEY0   = 4'd4;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int ST_BUSY       = 0;
  localparam int ST_DONE       = 1;
  localparam int ST_KEYS_VALID = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXPAND  = 2'd1,
    S_ROUND_A = 2'd2,
    S_ROUND_B = 2'd3
  } state_t;

  // 4-bit substitution used by every nibble of the 32-bit S-box
  function automatic logic [3:0] sbox_nibble(input logic [3:0] v);
    logic [3:0] s;
    case (v)
      4'h0: s = 4'hC;  4'h1: s = 4'h5;  4'h2: s = 4'h6;  4'h3: s = 4'hB;
      4'h4: s = 4'h9;  4'h5: s = 4'h0;  4'h6: s = 4'hA;  4'h7: s = 4'hD;
      4'h8: s = 4'h3;  4'h9: s = 4'hE;  4'hA: s = 4'hF;  4'hB: s = 4'h8;
      4'hC: s = 4'h4;  4'hD: s = 4'h7;  4'hE: s = 4'h1;  default: s = 4'h2;
    endcase
    return s;
  endfunction

  // One key-schedule step: rk -> rk'; the round key is the low half of rk'
  function automatic logic [127:0] ks_step(input logic [127:0] rk);
    logic [63:0] t;
    t = {rk[47:32], rk[63:48], rk[15:0], rk[31:16]};
    return {t, t ^ rk[127:64]};
  endfunction

endpackage

// File: rtl/feistel_f.sv
// Combinational Feistel round function F(R, K_i) built from SBOX_LANES S-boxes.
// With one lane the upper word is substituted in a first cycle (s_part, saved by
// the caller) and fed back through hi_saved while the lower word is substituted.
module feistel_f
  import feistel_cipher_pkg::*;
#(
  parameter int SBOX_LANES = 2
) (
  input  logic [63:0] r,
  input  logic [63:0] k,
  input  logic [3:0]  idx,
  input  logic        lo_sel,
  input  logic [31:0] hi_saved,
  output logic [63:0] f,
  output logic [31:0] s_part
);

  logic [63:0] x;
  logic [63:0] y;
  logic [63:0] p;
  logic [31:0] lane0_in;
  logic [31:0] lane0_out;
  logic [31:0] lane1_out;
  logic [31:0] hi_word;

  assign x        = r ^ k;
  assign lane0_in = (SBOX_LANES == 1 && !lo_sel) ? x[63:32] : x[31:0];

  sbox u_lane0 (.din(lane0_in), .dout(lane0_out));

  if (SBOX_LANES == 2) begin : g_two_lanes
    sbox u_lane1 (.din(x[63:32]), .dout(lane1_out));
  end else begin : g_one_lane
    assign lane1_out = '0;
  end

  assign hi_word = (SBOX_LANES == 2) ? lane1_out : hi_saved;
  assign s_part  = lane0_out;

  // Round-constant mix, half-swap and 21-bit left rotation
  always_comb begin
    y        = {hi_word, lane0_out};
    y[20:14] = y[20:14] ^ RC[idx];
    p        = {y[47:32], y[63:48], y[15:0], y[31:16]};
    f        = {p[42:0], p[63:43]};
  end

endmodule

// File: rtl/sbox.sv
// 32-bit S-box: eight parallel 4-bit substitutions.
module sbox
  import feistel_cipher_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Substitute each nibble independently
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    dout = '0;
    for (int n = 0; n < 8; n++) begin
      dout[4*n +: 4] = sbox_nibble(din[4*n +: 4]);
    end
  end

endmodule

// File: rtl/feistel_cipher_core.sv
// 128-bit Feistel block-cipher engine behind an Avalon-MM slave.
// CIPHER_DECRYPT_EN adds a precomputed round-key buffer, an EXPAND phase and decrypt mode;
// without it round keys are derived on the fly and the core is encrypt-only.
module feistel_cipher_core
  import feistel_cipher_pkg::*;
#(
  parameter int ROUNDS     = 12,
  parameter int SBOX_LANES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t         state, state_next;
  logic [127:0]   data_in, key, result, blk, rk, rk_next, blk_next;
  logic [63:0]    f_in, f_out, round_key;
  logic [31:0]    y_hi, s_part, rd_mux;
  logic [3:0]     idx;
  logic           busy, done, irq_en;
  logic           wr_ok, rd_ok, start_req, start_dec;
  logic           decrypt, kv_read, need_expand, last_round;
  logic           expand_step, hi_capture, round_done, lo_sel;

  // Only data/key/ctrl accesses stall while busy; STATUS and unmapped words never do
  assign waitrequest = (read | write) & busy & (address <= ADDR_CTRL);
  assign wr_ok       = write & ~waitrequest;
  assign rd_ok       = read & ~waitrequest;
  assign start_req   = wr_ok & (address == ADDR_CTRL) & writedata[CTRL_START];
  assign irq         = done & irq_en;
  assign rk_next     = ks_step(rk);

`ifdef CIPHER_DECRYPT_EN
  logic        mode, keys_valid;
  logic [63:0] kbuf [ROUNDS];
  assign decrypt     = mode;
  assign kv_read     = keys_valid;
  assign need_expand = ~keys_valid;
  assign start_dec   = writedata[CTRL_MODE];
  assign round_key   = kbuf[idx];

  // Round-key buffer, filled one entry per EXPAND cycle
  always_ff @(posedge clk) begin
    // NOTE: the key buffer is storage only; it is not reset, keys_valid guards its contents.
    if (expand_step) kbuf[idx] <= rk_next[63:0];
  end
`else
  assign decrypt     = 1'b0;
  assign kv_read     = 1'b1;
  assign need_expand = 1'b0;
  assign start_dec   = 1'b0;
  assign round_key   = rk_next[63:0];
`endif

  // Encrypt feeds F with R, decrypt with L
  assign f_in       = decrypt ? blk[127:64] : blk[63:0];
  assign blk_next   = decrypt ? {blk[63:0] ^ f_out, blk[127:64]}
                              : {blk[63:0], blk[127:64] ^ f_out};
  assign last_round = decrypt ? (idx == 4'd0) : (idx == LAST_IDX);

  feistel_f #(.SBOX_LANES(SBOX_LANES)) u_f (
    .r        (f_in),
    .k        (round_key),
    .idx      (idx),
    .lo_sel   (lo_sel),
    .hi_saved (y_hi),
    .f        (f_out),
    .s_part   (s_part)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: clocked state is assigned with <= so all registers update from pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start_req) state_next = need_expand ? S_EXPAND : S_ROUND_A;
      S_EXPAND:  if (idx == LAST_IDX) state_next = S_ROUND_A;
      S_ROUND_A: begin
        if (SBOX_LANES == 1)  state_next = S_ROUND_B;
        else if (last_round) state_next = S_IDLE;
      end
      S_ROUND_B: state_next = last_round ? S_IDLE : S_ROUND_A;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM outputs: datapath step controls decoded from the state
  always_comb begin
    expand_step = 1'b0;
    hi_capture  = 1'b0;
    round_done  = 1'b0;
    lo_sel      = 1'b0;
    case (state)
      S_EXPAND:  expand_step = 1'b1;
      S_ROUND_A: begin
        if (SBOX_LANES == 1) hi_capture = 1'b1;
        else                 round_done = 1'b1;
      end
      S_ROUND_B: begin
        lo_sel     = 1'b1;
        round_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file, status flags and round datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      data_in <= '0;
      key     <= '0;
      result  <= '0;
      blk     <= '0;
      rk      <= '0;
      y_hi    <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      irq_en  <= 1'b0;
`ifdef CIPHER_DECRYPT_EN
      mode       <= 1'b0;
      keys_valid <= 1'b0;
`endif
    end else begin
      if (wr_ok) begin
        if (address[3:2] == ADDR_DATA0[3:2]) begin
          data_in[{address[1:0], 5'b0} +: 32] <= writedata;
        end else if (address[3:2] == ADDR_KEY0[3:2]) begin
          key[{address[1:0], 5'b0} +: 32] <= writedata;
`ifdef CIPHER_DECRYPT_EN
          keys_valid <= 1'b0;
`endif
        end else if (address == ADDR_CTRL) begin
          irq_en <= writedata[CTRL_IRQ_EN];
`ifdef CIPHER_DECRYPT_EN
          mode   <= writedata[CTRL_MODE];
`endif
        end else if (address == ADDR_STATUS && writedata[ST_DONE]) begin
          done <= 1'b0;
        end
      end

      if (start_req) begin
        busy <= 1'b1;
        done <= 1'b0;
        blk  <= data_in;
        rk   <= key;
        idx  <= (!need_expand && start_dec) ? LAST_IDX : 4'd0;
      end

`ifdef CIPHER_DECRYPT_EN
      if (expand_step) begin
        rk <= rk_next;
        if (idx == LAST_IDX) begin
          keys_valid <= 1'b1;
          idx        <= mode ? LAST_IDX : 4'd0;
        end else begin
          idx <= idx + 4'd1;
        end
      end
`endif

      if (hi_capture) y_hi <= s_part;

      if (round_done) begin
        blk <= blk_next;
        rk  <= rk_next;
        if (last_round) begin
          result <= blk_next;
          busy   <= 1'b0;
          done   <= 1'b1;
        end else begin
          idx <= decrypt ? idx - 4'd1 : idx + 4'd1;
        end
      end
    end
  end

  // Read multiplexer; KEY and CTRL are write-only and read as zero
  always_comb begin
    rd_mux = '0;
    if (address[3:2] == ADDR_DATA0[3:2]) begin
      rd_mux = result[{address[1:0], 5'b0} +: 32];
    end else if (address == ADDR_STATUS) begin
      rd_mux[ST_BUSY]       = busy;
      rd_mux[ST_DONE]       = done;
      rd_mux[ST_KEYS_VALID] = kv_read;
    end
  end

  // Registered read data, updated when a read is accepted
  always_ff @(posedge clk) begin
    if (reset)      readdata <= '0;
    else if (rd_ok) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_feistel_cipher_core.sv
// Self-checking bench for feistel_cipher_core: one instance with two S-box lanes and
// one with a single lane, both ROUNDS = 12. Read data is checked by a scoreboard monitor;
// latency, stall lengths and irq are checked inline. Adapts to CIPHER_DECRYPT_EN.
module tb_feistel_cipher_core;

  localparam int R = 12;
`ifdef CIPHER_DECRYPT_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  localparam logic [127:0] PT  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] KEY = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [2];
  logic [3:0]  address     [2];
  logic        write       [2];
  logic        read        [2];
  logic [31:0] writedata   [2];
  logic [31:0] readdata    [2];
  logic        waitrequest [2];
  logic        irq         [2];

  feistel_cipher_core #(.ROUNDS(R), .SBOX_LANES(2)) u_dut_l2 (
    .clk(clk), .reset(rst[0]), .address(address[0]), .write(write[0]),
    .writedata(writedata[0]), .read(read[0]), .readdata(readdata[0]),
    .waitrequest(waitrequest[0]), .irq(irq[0])
  );

  feistel_cipher_core #(.ROUNDS(R), .SBOX_LANES(1)) u_dut_l1 (
    .clk(clk), .reset(rst[1]), .address(address[1]), .write(write[1]),
    .writedata(writedata[1]), .read(read[1]), .readdata(readdata[1]),
    .waitrequest(waitrequest[1]), .irq(irq[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] sb32(input logic [31:0] v);
    logic [3:0]  tab [16];
    logic [31:0] o;
    tab = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    for (int n = 0; n < 8; n++) o[4*n +: 4] = tab[v[4*n +: 4]];
    return o;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] blk, input logic [127:0] k, input bit dec);
    logic [6:0]   rc [16];
    logic [63:0]  ks [16];
    logic [127:0] rk;
    logic [63:0]  l, r, t, x, y, p, f;
    int           i;
    rc = '{7'h5A, 7'h5A, 7'h33, 7'h66, 7'h57, 7'h35, 7'h71, 7'h62,
           7'h5F, 7'h25, 7'h51, 7'h22, 7'h0B, 7'h16, 7'h2C, 7'h58};
    rk = k;
    for (int n = 0; n < R; n++) begin
      t     = {rk[47:32], rk[63:48], rk[15:0], rk[31:16]};
      rk    = {t, t ^ rk[127:64]};
      ks[n] = rk[63:0];
    end
    l = blk[127:64];
    r = blk[63:0];
    for (int s = 0; s < R; s++) begin
      i = dec ? (R - 1 - s) : s;
      x = (dec ? l : r) ^ ks[i];
      y = {sb32(x[63:32]), sb32(x[31:0])};
      y[20:14] = y[20:14] ^ rc[i];
      p = {y[47:32], y[63:48], y[15:0], y[31:16]};
      f = {p[42:0], p[63:43]};
      if (dec) {l, r} = {r ^ f, l};
      else     {l, r} = {r, l ^ f};
    end
    return {l, r};
  endfunction

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    int          inst;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t sb_q[$];
  logic acc_q [2] = '{1'b0, 1'b0};

  // Mid-cycle: note accepted reads, and compare read data one cycle after acceptance
  always begin
    @(negedge clk);
    #2;
    for (int j = 0; j < 2; j++) begin
      if (acc_q[j]) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 128'(sb_q.size()), 128'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_inst", 128'(j), 128'(e.inst));
          check(e.name, readdata[j], e.val);
        end
      end
      acc_q[j] <= !rst[j] && read[j] && !waitrequest[j];
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus(input int j, input bit rd, input logic [3:0] a, input logic [31:0] d,
                     output int stalls);
    logic w;
    @(negedge clk);
    address[j]   = a;
    read[j]      = rd;
    write[j]     = !rd;
    writedata[j] = d;
    stalls       = 0;
    forever begin
      #1;
      w = waitrequest[j];
      @(posedge clk);
      if (!w) break;
      stalls++;
      if (stalls > 400) begin
        check("bus_timeout", 128'(stalls), 128'd0);
        break;
      end
      @(negedge clk);
    end
    #1;
    read[j]  = 1'b0;
    write[j] = 1'b0;
  endtask

  task automatic wr(input int j, input logic [3:0] a, input logic [31:0] d);
    int s;
    bus(j, 1'b0, a, d, s);
  endtask

  task automatic rd_expect(input int j, input logic [3:0] a, input logic [31:0] e,
                           input string name, output int stalls);
    sb_q.push_back('{j, e, name});
    bus(j, 1'b1, a, 32'h0, stalls);
  endtask

  task automatic load(input int j, input logic [3:0] base, input logic [127:0] v);
    for (int w = 0; w < 4; w++) wr(j, base + 4'(w), v[32*w +: 32]);
  endtask

  task automatic read_block(input int j, input logic [127:0] e, input string name);
    int s;
    for (int w = 0; w < 4; w++) rd_expect(j, 4'(w), e[32*w +: 32], name, s);
  endtask

  // Counts cycles from the accepted start write until irq is seen
  task automatic wait_irq(input int j, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (irq[j] || n > 400) break;
    end
  endtask

  task automatic run_inst(input int j);
    int          lanes, rc, ex, n, s;
    logic [127:0] ct;
    logic [127:0] ct2;
    lanes = (j == 0) ? 2 : 1;
    rc    = R * (3 - lanes);
    ex    = DEC ? R : 0;
    ct    = model(PT, KEY, 1'b0);
    ct2   = model(ct, KEY, 1'b0);

    // Reset state
    #1;
    check("reset_readdata", readdata[j], 32'h0);
    check("reset_irq", irq[j], 1'b0);
    check("reset_waitrequest", waitrequest[j], 1'b0);
    rd_expect(j, 4'd9, DEC ? 32'h0 : 32'h4, "reset_status", s);
    check("idle_no_stall", 128'(s), 128'd0);
    rd_expect(j, 4'd0, 32'h0, "reset_data0", s);

    // First encrypt, with key expansion in the decrypt build
    load(j, 4'd0, PT);
    load(j, 4'd4, KEY);
    wr(j, 4'd8, 32'h5);
    wait_irq(j, n);
    check("latency_first", 128'(n), 128'(ex + rc));
    rd_expect(j, 4'd9, 32'h6, "status_done", s);
    read_block(j, ct, "ciphertext");

    // Second start with the same key: no expansion
    wr(j, 4'd8, 32'h5);
    #1;
    check("irq_cleared_by_start", irq[j], 1'b0);
    wait_irq(j, n);
    check("latency_keyed", 128'(n), 128'(rc));
    read_block(j, ct, "ciphertext_again");

    // Round trip (decrypt build) or mode-ignored second encryption
    load(j, 4'd0, ct);
    wr(j, 4'd8, 32'h7);
    wait_irq(j, n);
    check("latency_mode7", 128'(n), 128'(rc));
    read_block(j, DEC ? PT : ct2, "roundtrip");

    // STATUS never stalls; DATA read stalls until the cycle after busy falls
    load(j, 4'd0, PT);
    wr(j, 4'd8, 32'h5);
    rd_expect(j, 4'd9, 32'h5, "status_busy", s);
    check("status_no_stall", 128'(s), 128'd0);
    rd_expect(j, 4'd0, ct[31:0], "stalled_data0", s);
    check("data_stall_len", 128'(s), 128'(rc - 1));
    #1;
    check("irq_after_stall", irq[j], 1'b1);

    // KEY write mid-run stalls and invalidates the expanded keys
    wr(j, 4'd8, 32'h5);
    bus(j, 1'b0, 4'd4, KEY[31:0], s);
    check("key_stall_len", 128'(s), 128'(rc));
    rd_expect(j, 4'd9, DEC ? 32'h2 : 32'h6, "status_keys_cleared", s);
    wr(j, 4'd8, 32'h5);
    wait_irq(j, n);
    check("latency_reexpand", 128'(n), 128'(ex + rc));
    read_block(j, ct, "ciphertext_reexpand");

    // Reset in the ROUND_A cycle of round 5 aborts with no result
    wr(j, 4'd8, 32'h5);
    repeat ((lanes == 2) ? 5 : 10) @(posedge clk);
    #1;
    rst[j] = 1'b1;
    @(posedge clk);
    #1;
    rst[j] = 1'b0;
    check("midrun_reset_irq", irq[j], 1'b0);
    check("midrun_reset_readdata", readdata[j], 32'h0);
    rd_expect(j, 4'd9, DEC ? 32'h0 : 32'h4, "midrun_reset_status", s);
    rd_expect(j, 4'd0, 32'h0, "midrun_reset_data0", s);
  endtask

  initial begin
    for (int j = 0; j < 2; j++) begin
      rst[j]       = 1'b1;
      address[j]   = 4'd0;
      write[j]     = 1'b0;
      read[j]      = 1'b0;
      writedata[j] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int j = 0; j < 2; j++) run_inst(j);
    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
